// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one integer ALU between two requesters. Port 0 is the main issue
//   pipe and port 1 is the multi-word/microcode sequencer. One operation is
//   in flight at a time. The arbiter registers the operands for the ALU, then
//   captures the ALU result and flags one cycle later. It holds them until
//   the owning requester consumes them.
//   Sequence: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   : round-robin between requesters when both are valid
//   undefined : fixed priority, requester 0 always wins (last grant is still
//               tracked but not consulted)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous abort of the in-flight op
//   req_valid/ready    per-requester request handshake (ready is one-hot or 0)
//   req_op/a/b/rot     packed per-requester operands, slice i = requester i;
//                      req_rot slice is {rotn, MB, ME}
//   rsp_valid/ready    per-requester response handshake (valid one-hot)
//   rsp_c, rsp_d       captured ALU result and flag vector
//   alu_op/a/b/rotn/mb/me  registered operands driven to the ALU
//   alu_c, alu_d       combinational ALU result and flags
//   busy               high whenever the arbiter is not IDLE
module alu_arbiter #(
  parameter int AW  = 32,
  parameter int OPW = 5,
  parameter int RW  = 5,
  parameter int DW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OPW-1:0]  req_op,
  input  logic [2*AW-1:0]   req_a,
  input  logic [2*AW-1:0]   req_b,
  input  logic [6*RW-1:0]   req_rot,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [AW-1:0]     rsp_c,
  output logic [DW-1:0]     rsp_d,
  output logic [OPW-1:0]    alu_op,
  output logic [AW-1:0]     alu_a,
  output logic [AW-1:0]     alu_b,
  output logic [RW-1:0]     alu_rotn,
  output logic [RW-1:0]     alu_mb,
  output logic [RW-1:0]     alu_me,
  input  logic [AW-1:0]     alu_c,
  input  logic [DW-1:0]     alu_d,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     last_grant_q, last_grant_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [AW-1:0]  alu_a_q, alu_a_d;
  logic [AW-1:0]  alu_b_q, alu_b_d;
  logic [RW-1:0]  alu_rotn_q, alu_rotn_d;
  logic [RW-1:0]  alu_mb_q, alu_mb_d;
  logic [RW-1:0]  alu_me_q, alu_me_d;
  logic [AW-1:0]  rsp_c_q, rsp_c_d;
  logic [DW-1:0]  rsp_d_q, rsp_d_d;

  // Unpack the per-requester operand slices.
  logic [OPW-1:0] op_arr   [2];
  logic [AW-1:0]  a_arr    [2];
  logic [AW-1:0]  b_arr    [2];
  logic [RW-1:0]  rotn_arr [2];
  logic [RW-1:0]  mb_arr   [2];
  logic [RW-1:0]  me_arr   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_arr[gi]   = req_op[gi*OPW +: OPW];
    assign a_arr[gi]    = req_a[gi*AW +: AW];
    assign b_arr[gi]    = req_b[gi*AW +: AW];
    assign rotn_arr[gi] = req_rot[gi*3*RW + 2*RW +: RW];
    assign mb_arr[gi]   = req_rot[gi*3*RW + RW +: RW];
    assign me_arr[gi]   = req_rot[gi*3*RW +: RW];
  end

  // Grant is only possible in IDLE. A flush in that cycle suppresses it.
  logic [1:0] grant;
  logic       grant_sel;

  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && !flush) begin
`ifdef ALU_ARB_RR_EN
      // On a tie, the requester that did not win last time wins now.
      if (req_valid == 2'b11) begin
        grant = (last_grant_q == 2'b01) ? 2'b10 : 2'b01;
      end else begin
        grant = req_valid;
      end
`else
      if (req_valid[0]) begin
        grant = 2'b01;
      end else if (req_valid[1]) begin
        grant = 2'b10;
      end
`endif
    end
  end

  assign grant_sel = grant[1];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_rotn_d   = alu_rotn_q;
    alu_mb_d     = alu_mb_q;
    alu_me_d     = alu_me_q;
    rsp_c_d      = rsp_c_q;
    rsp_d_d      = rsp_d_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d      = EXEC;
          owner_d      = grant;
          last_grant_d = grant;
          alu_op_d     = op_arr[grant_sel];
          alu_a_d      = a_arr[grant_sel];
          alu_b_d      = b_arr[grant_sel];
          alu_rotn_d   = rotn_arr[grant_sel];
          alu_mb_d     = mb_arr[grant_sel];
          alu_me_d     = me_arr[grant_sel];
        end
      end
      EXEC: begin
        // A flushed op never gets its result captured.
        if (!flush) begin
          rsp_c_d = alu_c;
          rsp_d_d = alu_d;
        end
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the response.
        if ((rsp_ready & owner_q) != 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every transition, including a coincident rsp handshake.
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 2'b00;
      last_grant_q <= 2'b10;  // requester 0 wins the first tie
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_rotn_q   <= '0;
      alu_mb_q     <= '0;
      alu_me_q     <= '0;
      rsp_c_q      <= '0;
      rsp_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_rotn_q   <= alu_rotn_d;
      alu_mb_q     <= alu_mb_d;
      alu_me_q     <= alu_me_d;
      rsp_c_q      <= rsp_c_d;
      rsp_d_q      <= rsp_d_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == RESP) ? owner_q : 2'b00;
  assign busy      = (state_q != IDLE);
  assign rsp_c     = rsp_c_q;
  assign rsp_d     = rsp_d_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_rotn  = alu_rotn_q;
  assign alu_mb    = alu_mb_q;
  assign alu_me    = alu_me_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. It uses a small behavioural ALU
// (op 0 = add, op 1 = xor, other = and). The flags are
// {CA, OV, LT, GT, EQ, 3'b000}.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [29:0] req_rot;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_c;
  logic [7:0]  rsp_d;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_rotn;
  logic [4:0]  alu_mb;
  logic [4:0]  alu_me;
  logic [31:0] alu_c;
  logic [7:0]  alu_d;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rot   (req_rot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_d     (rsp_d),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_rotn  (alu_rotn),
    .alu_mb    (alu_mb),
    .alu_me    (alu_me),
    .alu_c     (alu_c),
    .alu_d     (alu_d),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stand-in.
  logic [32:0] sum;
  logic        ca;
  logic        ov;
  always_comb begin
    sum   = {1'b0, alu_a} + {1'b0, alu_b};
    ca    = 1'b0;
    ov    = 1'b0;
    alu_c = alu_a & alu_b;
    if (alu_op == 5'd0) begin
      alu_c = sum[31:0];
      ca    = sum[32];
      ov    = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    end else if (alu_op == 5'd1) begin
      alu_c = alu_a ^ alu_b;
    end
    alu_d = {ca, ov, alu_c[31], (!alu_c[31] && alu_c != 32'd0),
             (alu_c == 32'd0), 3'b000};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_rot   = '0;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({alu_a, alu_b, alu_op, alu_rotn, alu_mb, alu_me} !== '0)
      $display("FAIL reset_alu: got a=%h b=%h op=%h expected all zero", alu_a, alu_b, alu_op);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_c, rsp_d} !== 40'd0) $display("FAIL reset_rsp: got c=%h d=%h expected 0", rsp_c, rsp_d);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle_after_release: got busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single_op();
    req_op[4:0]   = 5'd0;
    req_a[31:0]   = 32'h7FFF_FFFF;
    req_b[31:0]   = 32'h0000_0001;
    req_rot[14:0] = {5'd3, 5'd7, 5'd21};
    req_valid     = 2'b01;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL single_req_ready: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    total_cnt++;
    if (alu_a !== 32'h7FFF_FFFF || alu_b !== 32'h1 || alu_op !== 5'd0)
      $display("FAIL single_alu_ops: got a=%h b=%h op=%h expected 7fffffff 00000001 00", alu_a, alu_b, alu_op);
    else pass_cnt++;
    total_cnt++;
    if (alu_rotn !== 5'd3 || alu_mb !== 5'd7 || alu_me !== 5'd21)
      $display("FAIL single_alu_rot: got %0d/%0d/%0d expected 3/7/21", alu_rotn, alu_mb, alu_me);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1 || rsp_valid !== 2'b00)
      $display("FAIL single_exec: got busy=%b rsp_valid=%b expected 1 00", busy, rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_c !== 32'h8000_0000 || rsp_d !== 8'h60)
      $display("FAIL single_rsp_data: got c=%h d=%h expected 80000000 60", rsp_c, rsp_d);
    else pass_cnt++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00)
      $display("FAIL single_done: got busy=%b rsp_valid=%b expected 0 00", busy, rsp_valid);
    else pass_cnt++;
    $display("txn single: req0 add 7fffffff+1 -> c=%h d=%h", rsp_c, rsp_d);
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_grant2;
    logic [31:0] exp_c2;
`ifdef ALU_ARB_RR_EN
    exp_grant2 = 2'b10;
    exp_c2     = 32'h0000_0000;
`else
    exp_grant2 = 2'b01;
    exp_c2     = 32'hFFFF_0000;
`endif
    do_reset();
    req_op    = {5'd0, 5'd1};
    req_a     = {32'hFFFF_FFFF, 32'hF0F0_0000};
    req_b     = {32'h0000_0001, 32'h0F0F_0000};
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rr_first_grant: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL rr_exec_ready: got %b expected 00", req_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_c !== 32'hFFFF_0000 || rsp_d !== 8'h20)
      $display("FAIL rr_first_rsp: got v=%b c=%h d=%h expected 01 ffff0000 20", rsp_valid, rsp_c, rsp_d);
    else pass_cnt++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    total_cnt++;
    if (req_ready !== exp_grant2) $display("FAIL rr_second_grant: got %b expected %b", req_ready, exp_grant2);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    total_cnt++;
    if (rsp_valid !== exp_grant2 || rsp_c !== exp_c2)
      $display("FAIL rr_second_rsp: got v=%b c=%h expected %b %h", rsp_valid, rsp_c, exp_grant2, exp_c2);
    else pass_cnt++;
    rsp_ready = exp_grant2;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rr_done: got busy=%b expected 0", busy);
    else pass_cnt++;
    $display("txn tie: second grant to %b c=%h", exp_grant2, rsp_c);
  endtask

  task automatic test_backpressure();
    req_op[4:0] = 5'd2;
    req_a[31:0] = 32'h1234_5678;
    req_b[31:0] = 32'h0000_FFFF;
    req_valid   = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b01 || rsp_c !== 32'h0000_5678 || rsp_d !== 8'h10)
        $display("FAIL bp_hold[%0d]: got v=%b c=%h d=%h expected 01 00005678 10", i, rsp_valid, rsp_c, rsp_d);
      else pass_cnt++;
      total_cnt++;
      if (req_ready !== 2'b00) $display("FAIL bp_req_ready[%0d]: got %b expected 00", i, req_ready);
      else pass_cnt++;
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL bp_done: got busy=%b expected 0", busy);
    else pass_cnt++;
    $display("txn backpressure: req0 and -> c=%h", rsp_c);
  endtask

  task automatic test_flush();
    req_op[4:0] = 5'd0;
    req_a[31:0] = 32'd1;
    req_b[31:0] = 32'd2;
    req_valid   = 2'b01;
    tick();
    req_valid = 2'b00;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00)
      $display("FAIL flush_exec: got busy=%b rsp_valid=%b expected 0 00", busy, rsp_valid);
    else pass_cnt++;
    req_valid = 2'b01;
    flush     = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL flush_idle_block: got %b expected 00", req_ready);
    else pass_cnt++;
    flush = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL flush_reaccept: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_c !== 32'd3 || rsp_d !== 8'h10)
      $display("FAIL flush_next_rsp: got v=%b c=%h d=%h expected 01 00000003 10", rsp_valid, rsp_c, rsp_d);
    else pass_cnt++;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    $display("txn flush: aborted op, reissued 1+2 -> c=%h", rsp_c);
  endtask

  task automatic test_async_reset();
    req_op[4:0] = 5'd0;
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd6;
    req_valid   = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    total_cnt++;
    if (rsp_valid !== 2'b01) $display("FAIL areset_pre: got %b expected 01", rsp_valid);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0)
      $display("FAIL areset_state: got v=%b busy=%b expected 00 0", rsp_valid, busy);
    else pass_cnt++;
    total_cnt++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || rsp_c !== 32'd0)
      $display("FAIL areset_regs: got a=%h b=%h c=%h expected 0", alu_a, alu_b, rsp_c);
    else pass_cnt++;
    #2;
    rst_n     = 1'b1;
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL areset_tie: got %b expected 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    $display("txn async reset: mid-RESP abort, first tie granted 01");
  endtask

  task automatic test_non_owner();
    req_op[9:5]   = 5'd0;
    req_a[63:32]  = 32'd5;
    req_b[63:32]  = 32'd7;
    req_valid     = 2'b10;
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL nonowner_grant: got %b expected 10", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b01;
    tick();
    total_cnt++;
    if (rsp_valid !== 2'b10 || busy !== 1'b1 || rsp_c !== 32'h0000_000C)
      $display("FAIL nonowner_ignored: got v=%b busy=%b c=%h expected 10 1 0000000c", rsp_valid, busy, rsp_c);
    else pass_cnt++;
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00)
      $display("FAIL nonowner_done: got busy=%b v=%b expected 0 00", busy, rsp_valid);
    else pass_cnt++;
    $display("txn non-owner: req1 add 5+7 -> c=%h", rsp_c);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_non_owner();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
